// File: rtl/vga_framebuf.sv
// Writable VGA frame memory: registered read port for vga_ctrl, write port for drawing logic,
// optional front/back double buffering with vblank-synchronous swap, and a back-bank clear engine.
module vga_framebuf #(
    parameter int unsigned H_BITS = 10,
    parameter int unsigned V_BITS = 9,
    parameter int unsigned PIX_W  = 24,
    parameter int unsigned DOUBLE = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [H_BITS-1:0] h_addr,
    input  logic [V_BITS-1:0] v_addr,
    input  logic              rd_en,
    output logic [PIX_W-1:0]  vga_data,
    input  logic              frame_start,
    input  logic              wr_en,
    input  logic [H_BITS-1:0] wr_h,
    input  logic [V_BITS-1:0] wr_v,
    input  logic [PIX_W-1:0]  wr_data,
    output logic              wr_ready,
    input  logic              swap_req,
    output logic              swap_pending,
    output logic              front,
    input  logic              clr_req,
    input  logic [PIX_W-1:0]  clr_data,
    output logic              busy
);

    localparam int unsigned ADDR_W = H_BITS + V_BITS;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    // Both banks share one array; the bank index is the top address bit (always 0 if single).
    logic [PIX_W-1:0]  r_mem [2*DEPTH];

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic [PIX_W-1:0]  r_clr_data;
    logic              r_front;
    logic              r_swap_pending;
    logic [PIX_W-1:0]  r_vga_data;

    logic              w_back;
    logic              w_mem_we;
    logic [ADDR_W:0]   w_wr_idx;
    logic [ADDR_W:0]   w_rd_idx;
    logic [PIX_W-1:0]  w_wr_data;

    assign w_back   = (DOUBLE != 0) ? ~r_front : r_front;
    assign w_rd_idx = {r_front, h_addr, v_addr};

    // Single write port: clear engine owns it while running, drawing logic otherwise.
    always_comb begin
        w_mem_we  = 1'b0;
        w_wr_idx  = {w_back, wr_h, wr_v};
        w_wr_data = wr_data;
        if (r_state == ST_CLEAR) begin
            w_mem_we  = 1'b1;
            w_wr_idx  = {w_back, r_clr_cnt};
            w_wr_data = r_clr_data;
        end else if (wr_en) begin
            w_mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_wr_idx] <= w_wr_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_vga_data <= '0;
        end else begin
            r_vga_data <= rd_en ? r_mem[w_rd_idx] : '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_clr_cnt  <= '0;
            r_clr_data <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (clr_req) begin
                        r_state    <= ST_CLEAR;
                        r_clr_cnt  <= '0;
                        r_clr_data <= clr_data;
                    end
                end
                ST_CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
                    if (&r_clr_cnt) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // A swap never lands mid-clear, so the displayed bank is always a finished one.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_front        <= 1'b0;
            r_swap_pending <= 1'b0;
        end else if (DOUBLE != 0) begin
            if (frame_start && r_swap_pending && (r_state == ST_IDLE)) begin
                r_front        <= ~r_front;
                r_swap_pending <= 1'b0;
            end else if (swap_req) begin
                r_swap_pending <= 1'b1;
            end
        end
    end

    assign vga_data     = r_vga_data;
    assign front        = r_front;
    assign swap_pending = r_swap_pending;
    assign busy         = (r_state == ST_CLEAR);
    assign wr_ready     = (r_state == ST_IDLE);

endmodule

// File: tb/tb_vga_framebuf.sv
// Directed bench for vga_framebuf: a double-buffered instance checked every cycle against a
// bank-array model, plus a single-bank instance checked with literal expectations.
module tb_vga_framebuf;

    logic       clk = 1'b0;
    logic       resetn;
    logic [2:0] h_addr, wr_h;
    logic [1:0] v_addr, wr_v;
    logic       rd_en, frame_start, wr_en, swap_req, clr_req;
    logic [7:0] wr_data, clr_data, vga_data;
    logic       wr_ready, swap_pending, front, busy;

    logic [2:0] sb_h_addr, sb_wr_h;
    logic [1:0] sb_v_addr, sb_wr_v;
    logic       sb_rd_en, sb_frame_start, sb_wr_en, sb_swap_req, sb_clr_req;
    logic [7:0] sb_wr_data, sb_clr_data, sb_vga_data;
    logic       sb_wr_ready, sb_swap_pending, sb_front, sb_busy;

    int checks = 0;
    int errors = 0;
    bit started = 0;

    always #5 clk = ~clk;

    vga_framebuf #(.H_BITS(3), .V_BITS(2), .PIX_W(8), .DOUBLE(1)) u_dut (
        .clk(clk), .resetn(resetn), .h_addr(h_addr), .v_addr(v_addr), .rd_en(rd_en),
        .vga_data(vga_data), .frame_start(frame_start), .wr_en(wr_en), .wr_h(wr_h),
        .wr_v(wr_v), .wr_data(wr_data), .wr_ready(wr_ready), .swap_req(swap_req),
        .swap_pending(swap_pending), .front(front), .clr_req(clr_req), .clr_data(clr_data),
        .busy(busy)
    );

    vga_framebuf #(.H_BITS(3), .V_BITS(2), .PIX_W(8), .DOUBLE(0)) u_sb (
        .clk(clk), .resetn(resetn), .h_addr(sb_h_addr), .v_addr(sb_v_addr), .rd_en(sb_rd_en),
        .vga_data(sb_vga_data), .frame_start(sb_frame_start), .wr_en(sb_wr_en), .wr_h(sb_wr_h),
        .wr_v(sb_wr_v), .wr_data(sb_wr_data), .wr_ready(sb_wr_ready), .swap_req(sb_swap_req),
        .swap_pending(sb_swap_pending), .front(sb_front), .clr_req(sb_clr_req),
        .clr_data(sb_clr_data), .busy(sb_busy)
    );

    // Model: two banks of 32 pixels, a remaining-fill count, and the displayed bank index.
    logic [7:0] m_mem [2][32];
    bit         m_known [2][32];
    int         m_clr_left = 0;
    logic [7:0] m_clr_col = 8'h00;
    bit         m_front = 0;
    bit         m_pend = 0;
    logic [7:0] m_vga = 8'h00;
    bit         m_vga_known = 1;

    always @(posedge clk or negedge resetn) begin : model
        int ridx;
        int widx;
        int back;
        bit was_busy;
        if (!resetn) begin
            m_front = 0; m_pend = 0; m_clr_left = 0; m_vga = 8'h00; m_vga_known = 1;
        end else begin
            ridx = {h_addr, v_addr};
            if (rd_en) begin
                m_vga = m_mem[m_front][ridx];
                m_vga_known = m_known[m_front][ridx];
            end else begin
                m_vga = 8'h00;
                m_vga_known = 1;
            end
            was_busy = (m_clr_left > 0);
            back = m_front ? 0 : 1;
            if (was_busy) begin
                widx = 32 - m_clr_left;
                m_mem[back][widx] = m_clr_col;
                m_known[back][widx] = 1;
                m_clr_left--;
            end else begin
                if (wr_en) begin
                    widx = {wr_h, wr_v};
                    m_mem[back][widx] = wr_data;
                    m_known[back][widx] = 1;
                end
                if (clr_req) begin
                    m_clr_col = clr_data;
                    m_clr_left = 32;
                end
            end
            if (frame_start && m_pend && !was_busy) begin
                m_front = !m_front;
                m_pend = 0;
            end else if (swap_req) begin
                m_pend = 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("busy", {31'd0, busy}, (m_clr_left > 0) ? 1 : 0);
            chk("wr_ready", {31'd0, wr_ready}, (m_clr_left > 0) ? 0 : 1);
            chk("front", {31'd0, front}, {31'd0, m_front});
            chk("swap_pending", {31'd0, swap_pending}, {31'd0, m_pend});
            if (m_vga_known) chk("vga_data", {24'd0, vga_data}, {24'd0, m_vga});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear(input logic [7:0] c);
        int n;
        clr_req = 1'b1; clr_data = c;
        tick();
        clr_req = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("clear_len", n, 32);
    endtask

    task automatic do_swap();
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0; frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic [7:0] exp;
        resetn = 1'b0;
        h_addr = 0; v_addr = 0; rd_en = 0; frame_start = 0; wr_en = 0; wr_h = 0; wr_v = 0;
        wr_data = 0; swap_req = 0; clr_req = 0; clr_data = 0;
        sb_h_addr = 0; sb_v_addr = 0; sb_rd_en = 0; sb_frame_start = 0; sb_wr_en = 0;
        sb_wr_h = 0; sb_wr_v = 0; sb_wr_data = 0; sb_swap_req = 0; sb_clr_req = 0;
        sb_clr_data = 0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        started = 1;

        chk("rst_vga", {24'd0, vga_data}, 0);
        chk("rst_front", {31'd0, front}, 0);
        chk("rst_pending", {31'd0, swap_pending}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_wr_ready", {31'd0, wr_ready}, 1);

        // Known background: bank1 = 0x11, bank0 = 0x22, bank0 displayed.
        do_clear(8'h11);
        do_swap();
        do_clear(8'h22);
        do_swap();
        chk("init_front", {31'd0, front}, 0);

        // Write lands in the back bank only.
        wr_en = 1; wr_h = 3'd2; wr_v = 2'd1; wr_data = 8'hA5;
        tick();
        wr_en = 0;
        chk("wr_front", {31'd0, front}, 0);
        h_addr = 3'd2; v_addr = 2'd1; rd_en = 1;
        tick();
        chk("wr_hidden", {24'd0, vga_data}, 8'h22);
        do_swap();
        chk("swap_front", {31'd0, front}, 1);
        tick();
        chk("swap_visible", {24'd0, vga_data}, 8'hA5);
        rd_en = 0;
        tick();
        chk("rd_off", {24'd0, vga_data}, 0);

        // Clear bank0 with a dropped mid-clear write and a deferred swap.
        clr_req = 1; clr_data = 8'h3C;
        tick();
        clr_req = 0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            swap_req = (n == 5); frame_start = (n == 10); wr_en = (n == 15);
            wr_h = 3'd5; wr_v = 2'd2; wr_data = 8'h99;
            tick();
            n++;
            if (n == 11) begin
                chk("defer_pending", {31'd0, swap_pending}, 1);
                chk("defer_front", {31'd0, front}, 1);
            end
            if (n == 16) chk("clr_wr_ready", {31'd0, wr_ready}, 0);
        end
        swap_req = 0; frame_start = 0; wr_en = 0;
        chk("clear_len", n, 32);
        frame_start = 1;
        tick();
        frame_start = 0;
        chk("late_swap_front", {31'd0, front}, 0);
        chk("late_swap_pending", {31'd0, swap_pending}, 0);
        for (int i = 0; i < 32; i++) begin
            h_addr = i[4:2]; v_addr = i[1:0]; rd_en = 1;
            tick();
            chk("clear_fill", {24'd0, vga_data}, 8'h3C);
        end
        rd_en = 0;

        // swap_req and frame_start together: swap deferred to the next frame_start.
        swap_req = 1; frame_start = 1;
        tick();
        swap_req = 0; frame_start = 0;
        chk("same_front", {31'd0, front}, 0);
        chk("same_pending", {31'd0, swap_pending}, 1);
        frame_start = 1;
        tick();
        frame_start = 0;
        chk("next_front", {31'd0, front}, 1);
        chk("next_pending", {31'd0, swap_pending}, 0);

        // clr_req + wr_en together, then asynchronous reset after 12 fill cycles.
        clr_req = 1; clr_data = 8'h44; wr_en = 1; wr_h = 3'd7; wr_v = 2'd3; wr_data = 8'h5A;
        swap_req = 1; rd_en = 1; h_addr = 0; v_addr = 0;
        tick();
        clr_req = 0; wr_en = 0; swap_req = 0;
        repeat (12) tick();
        chk("pre_rst_busy", {31'd0, busy}, 1);
        chk("pre_rst_pending", {31'd0, swap_pending}, 1);
        chk("pre_rst_vga", {24'd0, vga_data}, 8'h11);
        #1 resetn = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 0);
        chk("arst_pending", {31'd0, swap_pending}, 0);
        chk("arst_front", {31'd0, front}, 0);
        chk("arst_vga", {24'd0, vga_data}, 0);
        tick();
        resetn = 1'b1;
        for (int i = 0; i < 32; i++) begin
            h_addr = i[4:2]; v_addr = i[1:0]; rd_en = 1;
            tick();
            exp = (i < 12) ? 8'h44 : ((i == 31) ? 8'h5A : 8'h3C);
            chk("partial_fill", {24'd0, vga_data}, {24'd0, exp});
        end
        rd_en = 0;

        // Single-bank build: immediate visibility, read-old on collision, no swapping.
        sb_wr_en = 1; sb_wr_h = 3'd1; sb_wr_v = 2'd1; sb_wr_data = 8'h77;
        tick();
        sb_wr_en = 0; sb_rd_en = 1; sb_h_addr = 3'd1; sb_v_addr = 2'd1;
        tick();
        chk("sb_read", {24'd0, sb_vga_data}, 8'h77);
        sb_wr_en = 1; sb_wr_data = 8'h88;
        tick();
        sb_wr_en = 0;
        chk("sb_collision_old", {24'd0, sb_vga_data}, 8'h77);
        tick();
        chk("sb_collision_new", {24'd0, sb_vga_data}, 8'h88);
        sb_swap_req = 1;
        tick();
        sb_swap_req = 0;
        chk("sb_pending", {31'd0, sb_swap_pending}, 0);
        sb_frame_start = 1;
        tick();
        sb_frame_start = 0;
        chk("sb_front", {31'd0, sb_front}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_framebuf.md
Name: vga_framebuf

Overview:
Parametrised, writable VGA frame memory that replaces the static, file-initialised pixel ROM between the drawing logic and vga_ctrl. It has a registered pixel read port driven by h_addr/v_addr and a write port for drawing logic (CPU, keyboard echo). Optional double buffering swaps banks only during vertical blank. A hardware clear engine fills the back bank with a constant colour.

Parameters:
H_BITS, 10, horizontal address width.
V_BITS, 9, vertical address width; bank depth = 2^(H_BITS+V_BITS) words.
PIX_W, 24, pixel width in bits (RGB888 by default).
DOUBLE, 1, 1 = two banks (front/back) with swap; 0 = single bank, reads and writes share it.

Ports:
clk  in  1  pixel/system clock
resetn  in  1  asynchronous, active-low reset
h_addr  in  H_BITS  read column from vga_ctrl
v_addr  in  V_BITS  read row from vga_ctrl
rd_en  in  1  display-valid from vga_ctrl
vga_data  out  PIX_W  registered pixel to vga_ctrl
frame_start  in  1  one-cycle pulse at start of vertical blank
wr_en  in  1  pixel write request
wr_h  in  H_BITS  write column
wr_v  in  V_BITS  write row
wr_data  in  PIX_W  write pixel
wr_ready  out  1  write accepted when wr_en && wr_ready
swap_req  in  1  one-cycle pulse requesting a bank swap
swap_pending  out  1  swap requested, not yet performed
front  out  1  index of the displayed bank
clr_req  in  1  one-cycle pulse starting a fill of the back bank
clr_data  in  PIX_W  fill colour, latched on accepted clr_req
busy  out  1  clear engine running

Behaviour:
- Address = {h, v} (h in the MSBs), for both ports.
- Reset (resetn=0, asynchronous): vga_data=0, front=0, swap_pending=0, busy=0, state=IDLE, clear counter=0, wr_ready=1 after release. Memory contents are not reset.
- Read: 1-cycle latency. On each edge, vga_data <= rd_en ? mem[front][{h_addr,v_addr}] : 0.
- Back bank = ~front when DOUBLE=1; the same bank when DOUBLE=0.
- Write/read collision on the same bank and address (DOUBLE=0 only): the read returns the old data.
- FSM states: IDLE and CLEAR.
- IDLE:
  - wr_ready=1 and busy=0.
  - An accepted write updates the back bank at the edge.
  - clr_req latches clr_data, zeroes the counter and moves to CLEAR. A write in the same cycle is still performed.
- CLEAR:
  - busy=1 and wr_ready=0; wr_en is ignored and the data is dropped.
  - Each cycle writes the latched colour to back[counter], then counter++.
  - After writing address 2^(H_BITS+V_BITS)-1, the FSM returns to IDLE on the next edge. The clear takes exactly 2^(H_BITS+V_BITS) cycles.
  - clr_req is ignored while in CLEAR.
- Swap (DOUBLE=1):
  - swap_req sets swap_pending.
  - On a frame_start edge with swap_pending=1 and state=IDLE, front toggles and swap_pending clears.
  - If state=CLEAR, the swap stays pending until the first frame_start after the clear ends.
  - swap_req and frame_start in the same cycle: pending is set, and the swap waits for the next frame_start.
  - A repeated swap_req while pending has no additional effect.
- DOUBLE=0: swap_req is ignored; swap_pending=0 and front=0 permanently.
- Reset during CLEAR aborts the fill. Partial contents remain and busy=0.

Test Plan:
- Small parameters (H_BITS=3, V_BITS=2, PIX_W=8, DOUBLE=1).
- Reset then write: write 0xA5 at (h=2, v=1) → front=0 and display still reads old data; swap_req then frame_start → front=1, and reading (2,1) with rd_en=1 gives vga_data=0xA5 one cycle later; rd_en=0 → vga_data=0.
- Clear: clr_req with clr_data=0x3C → busy=1 for exactly 32 cycles, wr_ready=0 throughout; a wr_en issued mid-clear leaves its address at 0x3C; after swap, all 32 addresses read 0x3C.
- Deferred swap: swap_req at clear cycle 5, frame_start at cycle 10 → no toggle, swap_pending=1; first frame_start after busy falls → front toggles, swap_pending=0.
- Same-cycle events: swap_req and frame_start together → no toggle that frame, toggle at the next frame_start; clr_req and wr_en together in IDLE → the write lands, then the clear overwrites it.
- Reset mid-clear: assert resetn=0 at clear cycle 12 (asynchronously, between edges) → busy, swap_pending, front and vga_data read 0 immediately; addresses 0..11 read clr_data, the rest keep prior values.
- DOUBLE=0 build: write 0x77 at (1,1) → visible on the read port the next read cycle; swap_req → swap_pending stays 0 and front stays 0.
